host_write_sequencer: RTL

//  Controller for host->OPL3 register writes crossing into the synth clock domain.

---
 rtl/opl3_pkg.sv | 27 ++
 rtl/host_wr_fifo.sv | 87 ++++++++
 rtl/host_write_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/opl3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opl3_pkg
//  Description : Shared types for the OPL3 host write path. Holds the queued
//                host write record and the issue FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package opl3_pkg;

    localparam int OPL3_ADDR_WIDTH = 9;   // bit 8 selects the register bank
    localparam int OPL3_DATA_WIDTH = 8;

    // One queued host register write.
    typedef struct packed {
        logic [OPL3_ADDR_WIDTH-1:0] addr;
        logic [OPL3_DATA_WIDTH-1:0] data;
    } host_wr_t;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } wr_seq_state_t;

endpackage : opl3_pkg
`default_nettype wire

// File: rtl/host_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : host_wr_fifo
//  Description : Synchronous FIFO of host_wr_t records. Registered count and
//                full flag; a pushed entry becomes visible at the head only
//                on the following cycle (no fall-through).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_push/i_din  - write request and entry
//                i_pop         - remove head entry
//                o_dout        - head entry (valid while !o_empty)
//                o_full/o_empty/o_count - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module host_wr_fifo
    import opl3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  host_wr_t         i_din,
    input  logic             i_pop,
    output host_wr_t         o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    host_wr_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full;
    logic                 w_push;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_count_next;

    // Requests against a full/empty queue are ignored rather than corrupting it.
    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop  && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule : host_wr_fifo
`default_nettype wire

// File: rtl/host_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : host_write_sequencer
//  Description : Accepts toggle-handshake register writes from the host clock
//                domain, queues them, and replays them one at a time onto the
//                OPL3 register bus with a fixed idle gap between strobes.
//  Ports       : clk, reset           - synth clock, sync active-high reset
//                req_sync             - host request toggle (already synced)
//                addr_in, data_in     - host write, stable while pending
//                ack_tgl              - acknowledge toggle back to the host
//                opl_busy             - register file cannot accept a write
//                opl_wr               - one-cycle write strobe
//                opl_addr, opl_data   - write payload, held after the strobe
//                fifo_full, fifo_count- queue status
//  Revision    : 1.0 - initial release
// ============================================================================
module host_write_sequencer
    import opl3_pkg::*;
#(
    parameter int ADDR_WIDTH = OPL3_ADDR_WIDTH,
    parameter int DATA_WIDTH = OPL3_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_GAP     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_sync,
    input  logic [ADDR_WIDTH-1:0]         addr_in,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic                          ack_tgl,
    input  logic                          opl_busy,
    output logic                          opl_wr,
    output logic [ADDR_WIDTH-1:0]         opl_addr,
    output logic [DATA_WIDTH-1:0]         opl_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    wr_seq_state_t        r_state;
    wr_seq_state_t        w_state_next;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic                 r_ack_tgl;
    logic                 r_opl_wr;
    logic [ADDR_WIDTH-1:0] r_opl_addr;
    logic [DATA_WIDTH-1:0] r_opl_data;

    logic                 w_pending;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_CNT_W-1:0]   w_fifo_count;
    host_wr_t             w_push_entry;
    host_wr_t             w_head;

    // ------------------------------------------------------------------
    // Capture: a request is outstanding while the toggles differ. The ack
    // flips on the same edge as the push, which clears the request, so a
    // single handshake can never be queued twice. A full queue simply
    // leaves the ack untouched and the host waits.
    // ------------------------------------------------------------------
    assign w_pending         = req_sync ^ r_ack_tgl;
    assign w_push            = w_pending && !w_fifo_full;
    assign w_push_entry.addr = addr_in;
    assign w_push_entry.data = data_in;

    host_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Issue FSM. The busy input is consulted only when deciding to start
    // a write; once the strobe is launched the gap runs to completion.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty && !opl_busy) begin
                    w_state_next = ISSUE;
                    w_pop        = 1'b1;
                end
            end
            ISSUE: begin
                w_state_next = GAP;
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. On reset the ack tracks the current request so
    // the host observes an idle handshake and anything it had pending is
    // dropped along with the queue.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_tgl  <= req_sync;
            r_opl_wr   <= 1'b0;
            r_opl_addr <= '0;
            r_opl_data <= '0;
            r_gap_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_ack_tgl <= ~r_ack_tgl;
            end

            // The strobe is exactly the cycle spent in ISSUE.
            r_opl_wr <= w_pop;
            if (w_pop) begin
                r_opl_addr <= w_head.addr;
                r_opl_data <= w_head.data;
            end

            // Loaded while leaving ISSUE so GAP lasts WR_GAP cycles.
            if (r_state == ISSUE) begin
                r_gap_cnt <= c_GAP_W'(WR_GAP - 1);
            end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign ack_tgl    = r_ack_tgl;
    assign opl_wr     = r_opl_wr;
    assign opl_addr   = r_opl_addr;
    assign opl_data   = r_opl_data;
    assign fifo_full  = w_fifo_full;
    assign fifo_count = w_fifo_count;

endmodule : host_write_sequencer
`default_nettype wire
